// File: rtl/cic_pkg.sv
// cic_pkg -- shared helpers for the CIC interpolator slice.
//
// Contents:
//   CIC_MAX_W   widest intermediate value the narrowing helper handles
//   cic_growth  bit growth of an M-stage CIC with rate R and delay D
//   cic_narrow  reduce a sign-extended value to a signed width, either by
//               keeping the low bits (wrap) or by clamping to the signed range
package cic_pkg;

  localparam int CIC_MAX_W = 64;

  function automatic int cic_growth(input int r, input int d, input int m);
    return m * $clog2(r * d);
  endfunction

  // v must already be sign-extended to CIC_MAX_W bits. The result is again
  // sign-extended, so the caller simply keeps the low w bits.
  function automatic logic signed [CIC_MAX_W-1:0] cic_narrow(
    input logic signed [CIC_MAX_W-1:0] v,
    input int                          w,
    input logic                        sat
  );
    logic signed [CIC_MAX_W-1:0] one;
    logic signed [CIC_MAX_W-1:0] max_v;
    logic signed [CIC_MAX_W-1:0] min_v;
    logic signed [CIC_MAX_W-1:0] wrapped;
    one     = CIC_MAX_W'(1);
    max_v   = (one <<< (w - 1)) - one;
    min_v   = ~max_v;
    // Shift the kept field to the top, then back down arithmetically so
    // bit w-1 becomes the sign of the wrapped result.
    wrapped = (v <<< (CIC_MAX_W - w)) >>> (CIC_MAX_W - w);
    if (!sat) begin
      return wrapped;
    end else if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/cic_interp_comb.sv
// cic_interp_comb -- one comb stage of the CIC interpolator.
//
// A D-deep delay line that only shifts on accepted low-rate samples, plus a
// subtractor: c_out = c_in - (c_in as it was D accepts ago). Arithmetic wraps
// at PRECISION bits, which the CIC structure relies on.
//
// Ports:
//   clk     clock
//   rst_n   synchronous active-low reset, clears the delay line
//   accept  advance the delay line this cycle
//   c_in    stage input  (PRECISION bits, two's complement)
//   c_out   stage output (PRECISION bits, two's complement), combinational
module cic_interp_comb
  import cic_pkg::*;
#(
  parameter int PRECISION = 14,
  parameter int D         = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 accept,
  input  logic [PRECISION-1:0] c_in,
  output logic [PRECISION-1:0] c_out
);

  logic [PRECISION-1:0] delay_line [D];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) begin
        delay_line[i] <= '0;
      end
    end else if (accept) begin
      delay_line[0] <= c_in;
      for (int i = 1; i < D; i++) begin
        delay_line[i] <= delay_line[i-1];
      end
    end
  end

  // Unsigned subtraction at PRECISION bits is the same two's-complement wrap.
  assign c_out = c_in - delay_line[D-1];

endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator -- M-stage CIC interpolator by R with comb delay D.
//
// Low-rate samples enter through M comb stages, are zero-stuffed to the high
// rate, then pass through M registered integrators. One high-rate output is
// produced per step; a step happens every cycle of phases 1..R-1 and at
// phase 0 only when a new sample is accepted.
//
// Configuration macro:
//   CIC_INTERPOLATOR_SAT_EN  when defined the output is clamped to the signed
//                            Y_WIDTH range; otherwise the low bits are kept.
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset
//   enabled  global advance enable; low freezes all state and y
//   x        low-rate input sample, signed, X_WIDTH bits
//   x_valid  input sample present
//   x_ready  block can accept x this cycle (phase 0, enabled, not in reset)
//   y        high-rate output sample, signed, Y_WIDTH bits, registered
//   y_valid  y was updated by the previous step
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int R         = 2,
  parameter int D         = 1,
  parameter int M         = 2,
  parameter int X_WIDTH   = 12,
  parameter int PRECISION = X_WIDTH + cic_growth(R, D, M),
  parameter int Y_WIDTH   = PRECISION,
  parameter int OUT_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enabled,
  input  logic [X_WIDTH-1:0] x,
  input  logic               x_valid,
  output logic               x_ready,
  output logic [Y_WIDTH-1:0] y,
  output logic               y_valid
);

`ifdef CIC_INTERPOLATOR_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  localparam int            PW         = (R > 1) ? $clog2(R) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

  logic [PW-1:0]                 phase;
  logic                          accept;
  logic                          step;
  logic [M:0][PRECISION-1:0]     comb_sig;
  logic [PRECISION-1:0]          int_in;
  logic [M-1:0][PRECISION-1:0]   acc;
  logic [M-1:0][PRECISION-1:0]   acc_next;
  logic signed [PRECISION-1:0]   acc_out_shifted;
  logic [Y_WIDTH-1:0]            y_next;

  // Holding off x_ready during reset keeps a sample from being lost to a
  // cycle that is about to clear the pipeline.
  assign x_ready = rst_n && enabled && (phase == '0);
  assign accept  = x_valid && x_ready;
  // Phase 0 without a sample is a stall, not a zero insertion.
  assign step    = enabled && ((phase != '0) || x_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (step) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    end
  end

  assign comb_sig[0] = PRECISION'($signed(x));

  for (genvar i = 0; i < M; i++) begin : g_comb
    cic_interp_comb #(
      .PRECISION (PRECISION),
      .D         (D)
    ) u_comb (
      .clk    (clk),
      .rst_n  (rst_n),
      .accept (accept),
      .c_in   (comb_sig[i]),
      .c_out  (comb_sig[i+1])
    );
  end

  // Zero-stuffing: only the accepting step carries comb output.
  assign int_in = accept ? comb_sig[M] : '0;

  for (genvar i = 0; i < M; i++) begin : g_integ
    if (i == 0) begin : g_first
      assign acc_next[i] = acc[i] + int_in;
    end else begin : g_rest
      assign acc_next[i] = acc[i] + acc[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc_next;
    end
  end

  // y follows the last integrator's post-step value, so it updates on the
  // same edge as the integrators.
  assign acc_out_shifted = $signed(acc_next[M-1]) >>> OUT_SHIFT;

  always_comb begin
    y_next = Y_WIDTH'(cic_narrow(CIC_MAX_W'(acc_out_shifted), Y_WIDTH, SAT_EN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= step;
      if (step) begin
        y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator -- self-checking bench for cic_interpolator.
//
// The reference model treats the interpolator as a filter: every step feeds
// one zero-stuffed sample into a history, and the expected output is the
// convolution of that history with the CIC impulse response (M-fold
// convolution of a length R*D box), delayed by M-1 steps, wrapped to
// PRECISION bits and narrowed to Y_WIDTH bits. A negedge process compares
// y, y_valid and x_ready to the model every cycle; literal checks pin both
// the DUT and the model at hand-computed points.
module tb_cic_interpolator;

  localparam int R    = 2;
  localparam int D    = 1;
  localparam int M    = 2;
  localparam int XW   = 12;
  localparam int YW   = 12;
  localparam int OS   = 0;
  localparam int PREC = XW + M * $clog2(R * D);
  localparam int HLEN = M * (R * D - 1) + 1;
  localparam int HIST = HLEN + M;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          enabled = 1'b0;
  logic          x_valid = 1'b0;
  logic [XW-1:0] x       = '0;
  logic          x_ready;
  logic [YW-1:0] y;
  logic          y_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  longint h    [HLEN];
  longint hist [HIST];
  int     m_phase     = 0;
  longint exp_y       = 0;
  logic   exp_y_valid = 1'b0;

  always #5 clk = ~clk;

  cic_interpolator #(
    .R         (R),
    .D         (D),
    .M         (M),
    .X_WIDTH   (XW),
    .Y_WIDTH   (YW),
    .OUT_SHIFT (OS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enabled (enabled),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .y       (y),
    .y_valid (y_valid)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic en, input logic xv, input int xval);
    rst_n   = rn;
    enabled = en;
    x_valid = xv;
    x       = XW'(xval);
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_out(input longint v);
    longint w;
    longint hi;
    longint lo;
    w = v & ((64'sd1 <<< PREC) - 1);
    if (w >= (64'sd1 <<< (PREC - 1))) w = w - (64'sd1 <<< PREC);
    w  = w >>> OS;
    hi = (64'sd1 <<< (YW - 1)) - 1;
    lo = -(64'sd1 <<< (YW - 1));
`ifdef CIC_INTERPOLATOR_SAT_EN
    if (w > hi) w = hi;
    else if (w < lo) w = lo;
`else
    w = w & ((64'sd1 <<< YW) - 1);
    if (w > hi) w = w - (64'sd1 <<< YW);
`endif
    return w;
  endfunction

  function automatic longint model_y(input longint u);
    longint s = 0;
    longint v;
    for (int k = 0; k < HLEN; k++) begin
      int idx = M - 1 + k;
      v = (idx == 0) ? u : hist[idx-1];
      s = s + h[k] * v;
    end
    return model_out(s);
  endfunction

  function automatic logic model_step(input int ph, input logic en, input logic xv);
    return en && ((ph != 0) || xv);
  endfunction

  function automatic longint model_u(input int ph, input logic en, input logic xv, input logic [XW-1:0] xs);
    return (en && ph == 0 && xv) ? longint'($signed(xs)) : 64'sd0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < HIST; k++) hist[k] <= 0;
      m_phase     <= 0;
      exp_y       <= 0;
      exp_y_valid <= 1'b0;
    end else begin
      exp_y_valid <= model_step(m_phase, enabled, x_valid);
      if (model_step(m_phase, enabled, x_valid)) begin
        exp_y   <= model_y(model_u(m_phase, enabled, x_valid, x));
        hist[0] <= model_u(m_phase, enabled, x_valid, x);
        for (int k = 1; k < HIST; k++) hist[k] <= hist[k-1];
        m_phase <= (m_phase + 1) % R;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("y_vs_model", longint'($signed(y)), exp_y);
    checkOutput("y_valid_vs_model", longint'(y_valid), longint'(exp_y_valid));
    checkOutput("x_ready_vs_model", longint'(x_ready),
                longint'(rst_n && enabled && (m_phase == 0)));
  end

  task automatic checkLiteral(input string name, input longint y_exp, input logic yv_exp);
    checkOutput({name, "_y"}, longint'($signed(y)), y_exp);
    checkOutput({name, "_y_valid"}, longint'(y_valid), longint'(yv_exp));
    checkOutput({name, "_model_y"}, exp_y, y_exp);
  endtask

  initial begin
    longint tmp [HLEN];
    for (int k = 0; k < HLEN; k++) h[k] = 0;
    h[0] = 1;
    for (int s = 0; s < M; s++) begin
      for (int k = 0; k < HLEN; k++) begin
        tmp[k] = 0;
        for (int j = 0; j < R * D; j++) if (k - j >= 0) tmp[k] = tmp[k] + h[k-j];
      end
      h = tmp;
    end

    // Reset
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkLiteral("reset", 0, 1'b0);
    checkOutput("reset_x_ready", longint'(x_ready), 0);

    // Impulse: 0 (first step), then 1, 2, 1, 0
    applyStimulus(1, 1, 1, 1);
    checkLiteral("imp0", 0, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("imp1", 1, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("imp2", 2, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("imp3", 1, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("imp4", 0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0);

    // Enable gating mid-impulse
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("gate_pre", 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 5);
      checkLiteral("gate_hold", 1, 1'b0);
    end
    applyStimulus(1, 1, 1, 0);
    checkLiteral("gate_resume2", 2, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("gate_resume1", 1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0);

    // Backpressure at phase 0
    applyStimulus(1, 1, 1, 1);
    applyStimulus(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 0, 77);
      checkLiteral("bp_hold", 1, 1'b0);
      checkOutput("bp_x_ready", longint'(x_ready), 1);
    end
    applyStimulus(1, 1, 1, 0);
    checkLiteral("bp_resume2", 2, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("bp_resume1", 1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0);

    // DC step
    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 100);
    checkLiteral("dc_a", 200, 1'b1);
    applyStimulus(1, 1, 1, 100);
    checkLiteral("dc_b", 200, 1'b1);

    // Reset at phase 1 during DC
    applyStimulus(0, 1, 1, 100);
    checkLiteral("midreset", 0, 1'b0);
    rst_n   = 1'b1;
    enabled = 1'b1;
    x_valid = 1'b1;
    x       = XW'(1);
    #1;
    checkOutput("midreset_x_ready", longint'(x_ready), 1);
    applyStimulus(1, 1, 1, 1);
    checkLiteral("rimp0", 0, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("rimp1", 1, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("rimp2", 2, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkLiteral("rimp3", 1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0);

    // Saturation / wrap at full-scale DC
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, 2047);
`ifdef CIC_INTERPOLATOR_SAT_EN
    checkLiteral("sat", 2047, 1'b1);
`else
    checkLiteral("wrap", -2, 1'b1);
`endif

    // Reset with enabled low still clears
    applyStimulus(0, 0, 0, 0);
    checkLiteral("reset_disabled", 0, 1'b0);
    applyStimulus(1, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter R, default 2: interpolation factor, at least 2.
REQ-002 SHALL have parameter D, default 1: comb differential delay in low-rate samples, at least 1.
REQ-003 SHALL have parameter M, default 2: number of comb stages and number of integrator stages, at least 1.
REQ-004 SHALL have parameter X_WIDTH, default 12: input sample width, signed.
REQ-005 SHALL have parameter PRECISION, default X_WIDTH + M*clog2(R*D): internal accumulator width, signed.
REQ-006 SHALL have parameter Y_WIDTH, default PRECISION: output sample width, signed.
REQ-007 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift applied before output narrowing.
REQ-008 SHALL have port clk, input, 1 bit: clock.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-010 SHALL have port enabled, input, 1 bit: global advance enable.
REQ-011 SHALL have port x, input, X_WIDTH bits: low-rate input sample, signed.
REQ-012 SHALL have port x_valid, input, 1 bit: input sample present.
REQ-013 SHALL have port x_ready, output, 1 bit: block can accept an input sample.
REQ-014 SHALL have port y, output, Y_WIDTH bits: high-rate output sample, signed, registered.
REQ-015 SHALL have port y_valid, output, 1 bit: y updated this cycle.

Function
REQ-016 SHALL hold a phase counter in the range 0..R-1; x_ready = enabled && (phase == 0), combinationally.
REQ-017 SHALL define accept = x_valid && x_ready, and step = enabled && (phase != 0 || x_valid).
REQ-018 SHALL, on each step, advance phase modulo R (R-1 wraps to 0); when no step occurs, phase holds.
REQ-019 SHALL, on each accept, shift every comb delay line by one entry, storing its own stage input.
REQ-020 SHALL compute each comb stage combinationally as c_out = c_in - c_in delayed by D accepts; the stage-0 input is x sign-extended to PRECISION bits.
REQ-021 SHALL drive the integrator-chain input with the comb output on accept and with zero on any other step (zero-stuffing).
REQ-022 SHALL register each integrator: acc_i <= acc_i + in_i on step only; in_0 is the chain input, in_i = acc_(i-1).
REQ-023 SHALL perform all comb and integrator arithmetic at PRECISION bits with two's-complement wrap; wrap is required for correct CIC behaviour.
REQ-024 SHALL register y = narrow(acc_(M-1) >>> OUT_SHIFT) and assert y_valid for one cycle, one cycle after each step.
REQ-025 SHALL have latency of M steps from an accepted sample to its first contribution on y.
REQ-026 SHALL hold y and all state when enabled is low; a stall at phase 0 with x_valid low SHALL freeze the pipeline (no zero insertion at phase 0).
REQ-027 SHALL ignore x_valid while x_ready is low; x is not sampled in that case.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, clear phase, all delay lines, all accumulators, y and y_valid to zero, regardless of enabled.
REQ-029 SHALL hold x_ready low during a reset cycle; reset asserted mid-burst discards all in-flight samples, and the first accept after reset starts at phase 0.

Configuration
REQ-030 SHALL support macro CIC_INTERPOLATOR_SAT_EN: when defined, narrow() clamps to the signed Y_WIDTH range, to -2^(Y_WIDTH-1) and 2^(Y_WIDTH-1)-1.
REQ-031 SHALL, when CIC_INTERPOLATOR_SAT_EN is undefined, have narrow() keep the low Y_WIDTH bits (wrap); when Y_WIDTH >= PRECISION-OUT_SHIFT, the two behaviours are identical.

Structure
REQ-032 SHALL place the bit-growth function (clog2 of R*D times M) and the saturate/narrow helper function in the shared package cic_pkg.
REQ-033 SHALL implement the comb stage as one sub-module, cic_interp_comb, a D-deep delay line clocked by an accept enable plus a subtractor; integrators SHALL be inline generate logic.

Verification
REQ-034 Impulse: R=2, D=1, M=2; x=1 then 0s, x_valid held high -> y = 1, 2, 1, 0, 0... on consecutive y_valid cycles, first nonzero output 2 cycles after the accept.
REQ-035 DC step: R=2, D=1, M=2; x=100 continuous -> y settles to 200 on every y_valid, with no residual ripple after 4 cycles.
REQ-036 Backpressure: x_valid low at phase 0 for 5 cycles -> x_ready high, y_valid low, y held; the next accept resumes the output sequence unchanged.
REQ-037 Saturation: X_WIDTH=12, Y_WIDTH=12, x=2047 continuous, R=2, D=1, M=2 -> y = 2047 with CIC_INTERPOLATOR_SAT_EN defined, and the wrapped low 12 bits of 4094 without it.
REQ-038 Mid-run reset: rst_n low for 1 cycle at phase 1 during the DC step -> the next cycle has y=0, y_valid=0 and x_ready=1, and a repeated impulse reproduces 1, 2, 1.
REQ-039 Enable gating: enabled low for 3 cycles mid-impulse -> y frozen and y_valid low; the sequence continues unchanged once enabled returns high.
